// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder built from one 1-bit full-adder cell.
// The cell is reused over WIDTH clock cycles, one bit per cycle, LSB first.
// The controller owns the operand shift registers, the carry flop, the bit
// counter and the start/done handshake.
//
// Handshake: start is sampled only in IDLE or DONE. An accepted start loads
// the operands and carry-in on the same edge. busy is high whenever the FSM
// is not in IDLE. done is a one-cycle pulse during which s and c_out are
// valid. s and c_out then hold until the next accepted start.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output, which is
// the two's-complement overflow of the addition.

// Single full-adder cell shared by every bit position.
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);
   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // FSM state; observable hierarchically as state_q.
   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_cout;
   logic accept;
   logic last_bit;

   // start is only honoured when no addition is in progress.
   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_bit = (count_q == LAST_BIT);

   serial_adder_fa u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c_in  (carry_q),
      .s     (fa_s),
      .c_out (fa_cout)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load on accept, otherwise shift one bit per RUN cycle.
   always_comb begin
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      count_d = count_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      if (accept) begin
         a_sr_d  = a;
         b_sr_d  = b;
         s_sr_d  = '0;
         carry_d = c_in;
         count_d = '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_d   = 1'b0;
`endif
      end else if (state_q == RUN) begin
         a_sr_d = a_sr_q >> 1;
         b_sr_d = b_sr_q >> 1;
         // Sum bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
         s_sr_d = s_sr_q >> 1;
         s_sr_d[WIDTH-1] = fa_s;
         carry_d = fa_cout;
         if (!last_bit) count_d = count_q + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
         // carry_q is the carry into the MSB on the last bit.
         if (last_bit) ovf_d = carry_q ^ fa_cout;
`endif
      end
   end

   // Output decode from state; result outputs come straight from flops.
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   assign s     = s_sr_q;
   assign c_out = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         count_q <= count_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance checked every cycle against
// a transaction-level model (plain arithmetic + expected queue), plus
// directed vectors with literal expectations, and a 1-bit instance.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         c_out;
   logic         ovf;

   logic start1, a1, b1, c1, busy1, done1, s1, co1, ovf1;

   int n_checks;
   int n_errors;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .c_in  (c1),
      .busy  (busy1),
      .done  (done1),
      .s     (s1),
      .c_out (co1)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf1)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf  = 1'b0;
   assign ovf1 = 1'b0;
`endif

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference: {ovf, c_out, s} for a + b + c_in using plain integer math.
   function automatic logic [W+1:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci);
      int   u;
      int   sx, sy, sv;
      logic o;
      logic [W:0] uw;
      u  = int'(x) + int'(y) + int'(ci);
      uw = u[W:0];
      sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
      sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
      sv = sx + sy + int'(ci);
      o  = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
      return {o, uw};
   endfunction

   // Scoreboard / model state
   logic [W+1:0] exp_q[$];
   logic         m_init = 1'b0;
   logic         m_active, m_done, m_busy, m_valid, m_c, m_o;
   logic [W-1:0] m_s;
   int           m_left;

   // Model: an accepted addition completes W edges later; result comes from the queue.
   always @(posedge clk) begin
      logic [W+1:0] r;
      if (rst) begin
         m_init   = 1'b1;
         m_active = 1'b0;
         m_done   = 1'b0;
         m_busy   = 1'b0;
         m_valid  = 1'b1;
         m_s      = '0;
         m_c      = 1'b0;
         m_o      = 1'b0;
         m_left   = 0;
         exp_q.delete();
      end else if (m_init) begin
         m_done = 1'b0;
         if (m_active) begin
            m_left--;
            if (m_left == 0) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_valid  = 1'b1;
               if (exp_q.size() > 0) begin
                  r = exp_q.pop_front();
                  m_o = r[W+1];
                  m_c = r[W];
                  m_s = r[W-1:0];
               end
            end
         end else if (start) begin
            m_active = 1'b1;
            m_left   = W;
            m_valid  = 1'b0;
            exp_q.push_back(model_add(a, b, c_in));
         end
         m_busy = m_active || m_done;
      end
   end

   // Compare process: every cycle on the falling edge.
   always @(negedge clk) begin
      if (m_init) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         if (m_valid) begin
            check("s", s, m_s);
            check("c_out", c_out, m_c);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", ovf, m_o);
`endif
         end
      end
   end

   // Starts at a post-edge point; returns at the falling edge of the done
   // cycle. lat = number of the edge at which done is first sampled high.
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 40) begin
         lat++;
         @(negedge clk);
         if (done) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic scramble, input logic [W-1:0] es, input logic ec,
                        input logic eo, input string nm);
      int lat;
      a = ta; b = tb_v; c_in = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (scramble) begin
         a = 8'hAA; b = 8'hAA;
      end
      wait_done(lat);
      check({nm, "_latency"}, lat, 9);
      check({nm, "_s"}, s, es);
      check({nm, "_c_out"}, c_out, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check({nm, "_ovf"}, ovf, eo);
`else
      if (eo !== 1'b0 && eo !== 1'b1) check({nm, "_ovf_exp"}, eo, 0);
`endif
      @(posedge clk); #1;
      check({nm, "_busy_after"}, busy, 0);
      check({nm, "_s_hold"}, s, es);
   endtask

   initial begin
      int lat;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s", s, 0);
      check("rst_c_out", c_out, 0);
      check("rst_busy1", busy1, 0);
      check("rst_s1", s1, 0);
      @(posedge clk); #1;

      // Basic wrap-around and carry-in
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
      do_op(8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "0f_f0_ci");
      // Operands change during RUN
      do_op(8'h3C, 8'h42, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, "3c_42_scr");
      // Signed-overflow vectors
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
      do_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "80_80");
      do_op(8'h40, 8'h20, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0, "40_20");

      // start in RUN ignored, then back-to-back accept from DONE
      a = 8'h11; b = 8'h22; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
      check("run_start_latency", lat, 6);
      check("run_start_s", s, 8'h33);
      a = 8'h01; b = 8'h02; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_done_drop", done, 0);
      wait_done(lat);
      check("b2b_latency", lat, 9);
      check("b2b_s", s, 8'h03);
      check("b2b_c_out", c_out, 0);
      @(posedge clk); #1;
      check("b2b_busy_after", busy, 0);

      // Reset mid-RUN aborts
      a = 8'h55; b = 8'h55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_s", s, 8'h00);
      check("abort_c_out", c_out, 0);
      repeat (12) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
         @(posedge clk); #1;
      end
      do_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "post_abort");

      // WIDTH=1 instance
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (lat < 20) begin
         lat++;
         @(negedge clk);
         if (done1) break;
         @(posedge clk); #1;
      end
      check("w1_latency", lat, 2);
      check("w1_s", s1, 1);
      check("w1_c_out", co1, 1);
      @(posedge clk); #1;
      check("w1_busy_after", busy1, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencing controller that performs a WIDTH-bit addition by time-multiplexing a single 1-bit full-adder cell (a, b, c_in -> s, c_out) over WIDTH clock cycles. It owns the operand shift registers, the carry flop, the bit counter and a start/done handshake. It sits between a requesting block and the full-adder datapath, trading latency for area.

## Interface
- WIDTH, 8: operand and result width in bits; legal range WIDTH >= 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- c_in  input  1  carry-in; captured on an accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; s and c_out are valid.
- s  output  WIDTH  sum; held until the next accepted start.
- c_out  output  1  final carry; held until the next accepted start.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- Datapath: exactly one full-adder cell instantiated.
  - Inputs: A_sr[0], B_sr[0] and the carry flop.
  - Sum bit shifts into the MSB of S_sr.
  - A_sr and B_sr shift right each RUN cycle.
  - Carry flop takes the cell's c_out each RUN cycle.
- Counter: $clog2(WIDTH+1) bits; counts processed bits.
- FSM states and transitions:
  - IDLE -> RUN on start. The same edge loads A_sr=a, B_sr=b, carry=c_in, count=0 and clears S_sr.
  - RUN: processes one bit per cycle.
    - count == WIDTH-1 -> DONE; this edge processes the last bit.
    - Otherwise count++ and stay in RUN.
  - DONE: done=1, s=S_sr, c_out=carry.
    - start=1 -> RUN, with the same load actions as IDLE (back-to-back accept).
    - start=0 -> IDLE.
- start in RUN is ignored; it is neither queued nor an error.
- Operand changes after the accept edge have no effect on the result in progress.
- Arithmetic: {c_out, s} = a + b + c_in, unsigned, exact for all inputs.
- s and c_out outputs:
  - Both are registered.
  - While RUN, s shows the partially shifted S_sr; it is valid only when done=1 or in IDLE after done.
  - Internally, s is driven from S_sr.
  - Reset clears S_sr and carry.
  - A new accepted start clears S_sr.
- Reset:
  - Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0, ovf=0, count=0.
  - rst overrides start on the same edge.
  - rst mid-RUN aborts the operation; no done is issued.
- WIDTH=1: exactly one RUN cycle.

## Timing
- Accept edge E0: start=1 while in IDLE or DONE.
- busy goes high after E0.
- RUN occupies edges E1..EWIDTH; done is high in the cycle after EWIDTH.
  - Latency: done asserts WIDTH+1 cycles after the accept edge.
- Back-to-back: start held high in the DONE cycle gives a new accept at EWIDTH+1.
  - Throughput: one addition per WIDTH+1 cycles.
  - done drops; busy stays high.
- Without a new start, DONE -> IDLE at EWIDTH+1. busy=0 from then; s and c_out remain stable.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds the ovf port.
  - On the last RUN bit, ovf is registered as (carry into MSB) XOR (cell c_out), i.e. two's-complement overflow.
  - ovf has the same validity and hold rules as c_out.
  - Reset value of ovf is 0.
- SERIAL_ADDER_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, a=8'hFF, b=8'h01, c_in=0, start one cycle -> done exactly 9 cycles after the accept edge; s=8'h00, c_out=1, busy low the cycle after done.
- a=8'h0F, b=8'hF0, c_in=1 -> s=8'h00, c_out=1. Then a=8'h3C, b=8'h42, c_in=0, with a/b driven to 8'hAA during RUN -> s=8'h7E, c_out=0.
- start pulsed on RUN cycle 3 -> ignored, single done. start high during the DONE cycle with a=8'h01, b=8'h02 -> busy stays high; the second done gives s=8'h03 after 9 more cycles.
- rst asserted on RUN cycle 4 -> next edge IDLE, busy=0, done=0, s=8'h00, c_out=0; no done afterwards. A following start with a=8'h10, b=8'h20 -> s=8'h30.
- SERIAL_ADDER_OVF_EN on:
  - 8'h7F+8'h01 -> s=8'h80, c_out=0, ovf=1.
  - 8'h80+8'h80 -> s=8'h00, c_out=1, ovf=1.
  - 8'h40+8'h20 -> ovf=0.
- WIDTH=1, a=1, b=1, c_in=1 -> done 2 cycles after accept; s=1, c_out=1.
